// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_state_t;

    localparam int DT_WIDTH_DEF = 8;
    localparam int STAT_W       = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == {STAT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head register drives the stream, tail absorbs the
// word popped in the cycle the consumer stalls. All outputs are registers.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic [DT_WIDTH-1:0] i_push_data,
    input  logic                i_pop,
    input  logic                i_flush,
    output rd_state_t           o_state,
    output logic                o_valid,
    output logic [DT_WIDTH-1:0] o_data
);

    rd_state_t           r_state;
    logic                r_valid;
    logic [DT_WIDTH-1:0] r_head;
    logic [DT_WIDTH-1:0] r_tail;

    // Buffer state machine; flush wins over every other transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_head  <= {DT_WIDTH{1'b0}};
            r_tail  <= {DT_WIDTH{1'b0}};
        end else if (i_flush) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_push) begin
                        r_state <= ONE;
                        r_valid <= 1'b1;
                        r_head  <= i_push_data;
                    end else begin
                        r_state <= EMPTY;
                    end
                end
                ONE: begin
                    if (i_push && i_pop) begin
                        r_head <= i_push_data;
                    end else if (i_push) begin
                        r_state <= TWO;
                        r_tail  <= i_push_data;
                    end else if (i_pop) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end else begin
                        r_state <= ONE;
                    end
                end
                TWO: begin
                    if (i_pop) begin
                        r_state <= ONE;
                        r_head  <= r_tail;
                    end else begin
                        r_state <= TWO;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = r_state;
    assign o_valid = r_valid;
    assign o_data  = r_head;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to registered valid/ready stream adapter.
// Optional build macro FIFO_RD_STATS_EN adds saturating transfer and
// stall counters (stat_words, stat_stall); they survive flush.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [DT_WIDTH-1:0] fifo_rd_dt,
    output logic                fifo_rd_en,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DT_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_words,
    output logic [STAT_W-1:0]   stat_stall
`endif
);

    rd_state_t w_state;
    logic      w_rd_en;
    logic      w_pop;

    // Pop request depends only on registered state and FIFO status, never
    // on m_ready, so no combinational path crosses the adapter.
    assign w_rd_en    = !rst & !fifo_empty & !flush & (w_state != TWO);
    assign w_pop      = w_rd_en & !fifo_empty;
    assign fifo_rd_en = w_rd_en;

    fifo_rd_skid #(
        .DT_WIDTH (DT_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_pop),
        .i_push_data (fifo_rd_dt),
        .i_pop       (m_ready),
        .i_flush     (flush),
        .o_state     (w_state),
        .o_valid     (m_valid),
        .o_data      (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    logic [STAT_W-1:0] r_stat_words;
    logic [STAT_W-1:0] r_stat_stall;

    // Saturating transfer and stall counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_words <= {STAT_W{1'b0}};
            r_stat_stall <= {STAT_W{1'b0}};
        end else begin
            if (m_valid && m_ready) begin
                r_stat_words <= sat_inc(r_stat_words);
            end else begin
                r_stat_words <= r_stat_words;
            end
            if (m_valid && !m_ready) begin
                r_stat_stall <= sat_inc(r_stat_stall);
            end else begin
                r_stat_stall <= r_stat_stall;
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a small FIFO model.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_rd_dt;
    logic       fifo_rd_en;
    logic       flush = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stall;
`endif

    // FIFO model: combinational read, pointer advances on pop.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr;
    logic       fifo_clr = 1'b1;
    int         pop_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rd_dt = mem[rd_ptr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    fifo_rd_stream #(
        .DT_WIDTH (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_dt (fifo_rd_dt),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_clr = 1'b1;
        repeat (3) tick();
        push_word(8'hEE);
        #1;
        n_checks++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_en_in_reset: got %b expected 0", fifo_rd_en);
        end
        tick();
        rst = 1'b0;
        fifo_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle[%0d]: got valid=%b data=%h rd_en=%b expected 0/00/0",
                         i, m_valid, m_data, fifo_rd_en);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(i[7:0]);
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_start: got valid=%b rd_en=%b expected 0/1", m_valid, fifo_rd_en);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== i[7:0]) begin
                n_fail++;
                $display("FAIL stream_word[%0d]: got valid=%b data=%h expected 1/%h",
                         i, m_valid, m_data, i[7:0]);
            end
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got valid=%b expected 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        logic [7:0] exp_d;
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 5; i++) push_word(8'h21 + i[7:0]);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h21) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1/21", k, m_valid, m_data);
            end
        end
        n_checks++;
        if (pop_cnt - p0 !== 2 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pops: got pops=%0d rd_en=%b expected 2/0", pop_cnt - p0, fifo_rd_en);
        end
        m_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            exp_d = 8'h21 + k[7:0];
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: got valid=%b data=%h expected 1/%h", k, m_valid, m_data, exp_d);
            end
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: got valid=%b expected 0", m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        int p0;
        m_ready = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        push_word(8'hA4);
        tick();
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA1 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre: got valid=%b data=%h rd_en=%b expected 1/a1/0", m_valid, m_data, fifo_rd_en);
        end
        p0 = pop_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || pop_cnt !== p0 || fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle: got valid=%b pops=%0d rd_en=%b expected 0/%0d/1",
                     m_valid, pop_cnt, fifo_rd_en, p0);
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA3) begin
            n_fail++;
            $display("FAIL flush_next: got valid=%b data=%h expected 1/a3", m_valid, m_data);
        end
        m_ready = 1'b1;
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA4) begin
            n_fail++;
            $display("FAIL flush_a4: got valid=%b data=%h expected 1/a4", m_valid, m_data);
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: got valid=%b expected 0", m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hB1 || fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got valid=%b data=%h rd_en=%b expected 1/b1/1", m_valid, m_data, fifo_rd_en);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got valid=%b data=%h rd_en=%b expected 0/00/0",
                     m_valid, m_data, fifo_rd_en);
        end
        fifo_clr = 1'b1;
        tick();
        rst = 1'b0;
        fifo_clr = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_after: got valid=%b rd_en=%b expected 0/0", m_valid, fifo_rd_en);
        end
    endtask

`ifdef FIFO_RD_STATS_EN
    task automatic test_stats();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'hC1 + i[7:0]);
        tick();
        repeat (3) tick();
        m_ready = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (stat_words !== 16'd5 || stat_stall !== 16'd3 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stats_count: got words=%0d stall=%0d valid=%b expected 5/3/0",
                     stat_words, stat_stall, m_valid);
        end
        m_ready = 1'b0;
        push_word(8'hD1);
        tick();
        repeat (65540) tick();
        n_checks++;
        if (stat_stall !== 16'hFFFF || stat_words !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_saturate: got stall=%h words=%0d expected ffff/5", stat_stall, stat_words);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef FIFO_RD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
